rom_fetch_unit: RTL and testbench

//  Bus initiator for the synchronous program ROM: drives ROM address, absorbs the ROM's
//  1-cycle registered read latency, queues fetched bytes with their addresses, and offers

---
 rtl/rom_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/rom_fetch_unit.sv | 103 ++++++++++
 tb/tb_rom_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and defaults for the ROM fetch unit: FSM state encoding and queue entry sizing.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // A queued entry carries the fetch address above the fetched byte.
  function automatic int entry_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with clear; head is visible combinationally on rd_data.
// Write and read in the same cycle are both honoured, even when full.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared on reset so the head never shows X while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Prefetches bytes from a 1-cycle-latency ROM into a small queue and offers them to the decoder.
// A jump flushes queued and in-flight bytes; the target byte is valid three cycles later.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr
);

  localparam int ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic [ENTRY_W-1:0]    head;
  logic                  jump_take;
  logic                  issue;
  logic                  pop;
  logic [OCC_W-1:0]      occ;

  assign instr_valid = !empty;
  assign instr       = head[DATA_WIDTH-1:0];
  assign instr_addr  = head[ENTRY_W-1 -: ADDR_WIDTH];
  assign pop         = instr_valid && instr_ready;

  // Credit: queued entries plus the byte still in the ROM pipe, less this cycle's pop.
  assign occ = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

  always_comb begin
    state_next = state;
    jump_take  = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN, ST_REDIRECT: begin
        jump_take  = jump_en;
        state_next = jump_en ? ST_REDIRECT : ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
    issue = !jump_take && (occ < OCC_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      rom_addr   <= RESET_ADDR;
      inflight   <= 1'b0;
      fetch_addr <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (jump_take) begin
        rom_addr <= jump_addr;
      end else if (issue) begin
        rom_addr <= rom_addr + ADDR_WIDTH'(1);
      end
      if (issue) begin
        fetch_addr <= rom_addr;
      end
    end
  end

  // Clear wins inside the queue, so the byte landing on a jump edge is dropped.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (jump_take),
    .wr      (inflight),
    .wr_data ({fetch_addr, rom_data}),
    .rd      (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  wr_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && full && !pop && !jump_take));

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit paired with a registered ROM holding rom[i] = i ^ 8'hA5.
module tb_rom_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [7:0] instr_addr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;

  logic [7:0] rom [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  rom_fetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .RESET_ADDR (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr)
  );

  typedef struct {
    string      tag;
    bit         rst;
    bit         ready;
    bit         jump;
    logic [7:0] jaddr;
    int         ev;
    logic [7:0] ea;
    int         ra;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, bit rst, bit rdy, bit jmp, logic [7:0] ja,
                              int ev, logic [7:0] ea, int ra);
    vec_t r;
    r.tag = tag; r.rst = rst; r.ready = rdy; r.jump = jmp; r.jaddr = ja;
    r.ev = ev; r.ea = ea; r.ra = ra;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one time step after a posedge with reset released: that cycle is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    jump_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         cyc;
    vec_t       t;
    logic [7:0] exp_next;
    logic [7:0] prev_a;
    logic [7:0] prev_d;
    int         last_jump;
    int         rate;
    int         delivered;
    bit         prev_pop;
    bit         prev_hold;

    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;

    // Stream from reset with READY high.
    vecs.push_back(mk("stream", 1, 1, 0, 8'h00, 0, 8'h00, 8'h00));
    vecs.push_back(mk("stream", 0, 1, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk("stream", 0, 1, 0, 8'h00, 1, 8'h00, 8'h02));
    vecs.push_back(mk("stream", 0, 1, 0, 8'h00, 1, 8'h01, 8'h03));
    vecs.push_back(mk("stream", 0, 1, 0, 8'h00, 1, 8'h02, 8'h04));
    vecs.push_back(mk("stream", 0, 1, 0, 8'h00, 1, 8'h03, 8'h05));
    // Backpressure: queue fills, ROM address parks at 04, then drains in order.
    vecs.push_back(mk("fill", 1, 0, 0, 8'h00, 0, 8'h00, 8'h00));
    vecs.push_back(mk("fill", 0, 0, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk("fill", 0, 0, 0, 8'h00, 1, 8'h00, 8'h02));
    vecs.push_back(mk("fill", 0, 0, 0, 8'h00, 1, 8'h00, 8'h03));
    for (int i = 4; i < 10; i++) vecs.push_back(mk("fill", 0, 0, 0, 8'h00, 1, 8'h00, 8'h04));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h00, 8'h04));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h01, 8'h05));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h02, 8'h06));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h03, 8'h07));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h04, 8'h08));
    vecs.push_back(mk("drain", 0, 1, 0, 8'h00, 1, 8'h05, 8'h09));
    // Wrap through FF.
    vecs.push_back(mk("wrap", 1, 1, 0, 8'h00, 0, 8'h00, 8'h00));
    vecs.push_back(mk("wrap", 0, 1, 1, 8'hFD, 0, 8'h00, 8'h01));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 0, 8'h00, 8'hFD));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 0, 8'h00, 8'hFE));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 1, 8'hFD, 8'hFF));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 1, 8'hFE, 8'h00));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 1, 8'hFF, 8'h01));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 1, 8'h00, 8'h02));
    vecs.push_back(mk("wrap", 0, 1, 0, 8'h00, 1, 8'h01, 8'h03));
    // Jump with three queued and one in flight.
    vecs.push_back(mk("flush", 1, 0, 0, 8'h00, 0, 8'h00, 8'h00));
    vecs.push_back(mk("flush", 0, 0, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk("flush", 0, 0, 0, 8'h00, 1, 8'h00, 8'h02));
    vecs.push_back(mk("flush", 0, 0, 0, 8'h00, 1, 8'h00, 8'h03));
    vecs.push_back(mk("flush", 0, 1, 1, 8'h40, 1, 8'h00, 8'h04));
    vecs.push_back(mk("flush", 0, 1, 0, 8'h00, 0, 8'h00, 8'h40));
    vecs.push_back(mk("flush", 0, 1, 0, 8'h00, 0, 8'h00, 8'h41));
    vecs.push_back(mk("flush", 0, 1, 0, 8'h00, 1, 8'h40, 8'h42));
    vecs.push_back(mk("flush", 0, 1, 0, 8'h00, 1, 8'h41, 8'h43));
    vecs.push_back(mk("flush", 0, 1, 0, 8'h00, 1, 8'h42, 8'h44));
    // Back-to-back jumps; the pop offered on the first jump is ignored.
    vecs.push_back(mk("b2b", 1, 1, 0, 8'h00, 0, 8'h00, 8'h00));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 0, 8'h00, 8'h01));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 1, 8'h00, 8'h02));
    vecs.push_back(mk("b2b", 0, 1, 1, 8'h10, 1, 8'h01, 8'h03));
    vecs.push_back(mk("b2b", 0, 1, 1, 8'h20, 0, 8'h00, 8'h10));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 0, 8'h00, 8'h20));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 0, 8'h00, 8'h21));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 1, 8'h20, 8'h22));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 1, 8'h21, 8'h23));
    vecs.push_back(mk("b2b", 0, 1, 0, 8'h00, 1, 8'h22, 8'h24));

    cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      if (t.rst) begin
        do_reset();
        cyc = 0;
      end else begin
        tick();
        cyc++;
      end
      instr_ready = t.ready;
      jump_en     = t.jump;
      jump_addr   = t.jaddr;
      if (t.ev >= 0)
        check($sformatf("%s c%0d valid", t.tag, cyc), 32'(instr_valid), 32'(t.ev == 1));
      if (t.ev == 1) begin
        check($sformatf("%s c%0d instr_addr", t.tag, cyc), 32'(instr_addr), 32'(t.ea));
        check($sformatf("%s c%0d instr", t.tag, cyc), 32'(instr), 32'(t.ea ^ 8'hA5));
      end
      if (t.ra >= 0)
        check($sformatf("%s c%0d rom_addr", t.tag, cyc), 32'(rom_addr), 32'(t.ra));
    end

    // Reset asserted mid-cycle with the queue full.
    do_reset();
    repeat (7) tick();
    check("rstmid full valid", 32'(instr_valid), 32'd1);
    check("rstmid full rom_addr", 32'(rom_addr), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid valid", 32'(instr_valid), 32'd0);
    check("rstmid instr", 32'(instr), 32'h00);
    check("rstmid instr_addr", 32'(instr_addr), 32'h00);
    check("rstmid rom_addr", 32'(rom_addr), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("rstmid c1 valid", 32'(instr_valid), 32'd0);
    tick();
    check("rstmid c2 instr_addr", 32'(instr_addr), 32'h00);
    check("rstmid c2 instr", 32'(instr), 32'hA5);
    tick();
    check("rstmid c3 instr_addr", 32'(instr_addr), 32'h01);
    check("rstmid c3 instr", 32'(instr), 32'hA4);

    // Randomised READY and jumps against an address-stream reference.
    do_reset();
    cyc = 0;
    exp_next = 8'h00;
    last_jump = -100;
    prev_pop = 1'b0;
    prev_hold = 1'b0;
    prev_a = 8'h00;
    prev_d = 8'h00;
    rate = 70;
    delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin
        tick();
        cyc++;
      end
      if (cyc % 100 == 0) rate = int'($urandom_range(0, 100));
      if (cyc == 2) check("rnd first valid", 32'(instr_valid), 32'd1);
      if (cyc == last_jump + 1 || cyc == last_jump + 2)
        check($sformatf("rnd c%0d flushed", cyc), 32'(instr_valid), 32'd0);
      if (cyc == last_jump + 3)
        check($sformatf("rnd c%0d target valid", cyc), 32'(instr_valid), 32'd1);
      if (prev_hold) begin
        check($sformatf("rnd c%0d hold valid", cyc), 32'(instr_valid), 32'd1);
        check($sformatf("rnd c%0d hold addr", cyc), 32'(instr_addr), 32'(prev_a));
        check($sformatf("rnd c%0d hold data", cyc), 32'(instr), 32'(prev_d));
      end
      if (prev_pop) check($sformatf("rnd c%0d no bubble", cyc), 32'(instr_valid), 32'd1);

      instr_ready = (int'($urandom_range(0, 99)) < rate);
      jump_en     = (cyc >= 3) && ($urandom_range(0, 24) == 0);
      jump_addr   = 8'($urandom);

      prev_pop  = instr_valid && instr_ready && !jump_en;
      prev_hold = instr_valid && !instr_ready && !jump_en;
      prev_a    = instr_addr;
      prev_d    = instr;
      if (prev_pop) begin
        check($sformatf("rnd c%0d deliver addr", cyc), 32'(instr_addr), 32'(exp_next));
        check($sformatf("rnd c%0d deliver data", cyc), 32'(instr), 32'(exp_next ^ 8'hA5));
        exp_next = exp_next + 8'd1;
        delivered++;
      end
      if (jump_en) begin
        exp_next  = jump_addr;
        last_jump = cyc;
      end
    end
    check("rnd enough deliveries", 32'(delivered > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
